// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch stage: datapath width,
// default reset PC and buffer depth, the fetch FSM state type, and the
// decoder opcode field values for branch/jal/jalr. These are used by the
// fetch RTL, the decoder and the benches.
// No ports (package).
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam int              DEFAULT_BUF_DEPTH = 2;

  // Values of inst[6:2] for control-transfer instructions
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  // FETCH: may issue a request, WAIT: one request outstanding,
  // DRAIN: outstanding request was redirected away, its data is dropped,
  // HALT: misaligned redirect seen, only reset leaves this state
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Instruction memory read bus between the fetch stage and instruction memory.
// Request channel: req_valid/req_ready handshake with a word-aligned byte
// address. Response channel: rsp_valid qualifies rsp_data; there is no
// backpressure on responses.
//   master modport : fetch stage (drives req_valid, addr)
//   slave modport  : instruction memory (drives req_ready, rsp_valid, rsp_data)
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// ---------------------------------------------------------------------------
// instr_fetch_fifo
// Small instruction buffer for the fetch stage. Holds DEPTH entries of
// WIDTH bits ({pc, inst} in the fetch stage). Synchronous reset and a
// synchronous clear that wins over push and pop in the same cycle.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clear       drop all entries this cycle
//   push        write push_data at the tail (caller guarantees not full)
//   pop         discard the head entry (caller guarantees not empty)
//   push_data   entry to write
//   head        current head entry (stale when empty)
//   empty       no entries held
//   count       number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module instr_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Storage needs no reset: count says which slots are meaningful
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Fetch stage in front of the main decoder. Owns the PC, issues one word
// read at a time to instruction memory, buffers returned words with their
// PC, and presents the head instruction, its PC and opcode field inst[6:2].
// Redirects (taken branch / jal / jalr) flush the buffer and restart fetch;
// a misaligned redirect target halts fetch until reset.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem            instruction memory bus (instr_fetch_if.master)
//   redirect_valid  redirect this cycle
//   redirect_pc     new fetch target
//   stall           decoder cannot take the head instruction
//   inst_valid      head instruction valid
//   inst, inst_pc   head instruction and its PC (zero when empty)
//   opcode          inst[6:2]
//   misalign_err    sticky, set by a misaligned redirect target
// Optional feature (macro FETCH_PERF_CNT_EN): adds perf_fetched (entries
// pushed) and perf_flushed (entries or responses thrown away by redirects).
// ---------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  instr_fetch_if.master    imem,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             stall,
  output logic             inst_valid,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  inst_pc,
  output logic [4:0]       opcode,
  output logic             misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]  perf_fetched,
  output logic [XLEN-1:0]  perf_flushed
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t      state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   req_pc;

  logic              flush;
  logic              misaligned;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic [2*XLEN-1:0] fifo_head;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // A redirect in HALT is ignored: fetch is dead until reset
  assign flush      = redirect_valid && (state != HALT);
  assign misaligned = redirect_pc[1:0] != 2'b00;

  // Only FETCH issues, so at most one request is ever outstanding. Issuing
  // only while a slot is free reserves room for the response.
  assign imem.req_valid = !rst && (state == FETCH) && !redirect_valid &&
                          (fifo_count < CNT_W'(BUF_DEPTH));
  assign imem.addr      = pc;
  assign req_fire       = imem.req_valid && imem.req_ready;

  // A response arriving with a redirect is dropped; in FETCH/DRAIN/HALT
  // a response is stale and never pushed
  assign push = (state == WAIT) && imem.rsp_valid && !redirect_valid;
  assign pop  = !fifo_empty && !stall && !flush;

  instr_fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2*XLEN)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .pop       (pop),
    .push_data ({req_pc, imem.rsp_data}),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Fetch control. A redirect outranks the normal flow. When it catches a
  // request in flight we must still swallow that response (DRAIN), unless
  // the response shows up in the redirect cycle itself, in which case it is
  // dropped right there and fetch can restart immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (flush) begin
      if (misaligned) begin
        state        <= HALT;
        misalign_err <= 1'b1;
      end else begin
        pc <= redirect_pc;
        case (state)
          WAIT, DRAIN: state <= imem.rsp_valid ? FETCH : DRAIN;
          default:     state <= FETCH;
        endcase
      end
    end else begin
      case (state)
        FETCH: begin
          if (req_fire) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end
        end
        WAIT, DRAIN: begin
          if (imem.rsp_valid) begin
            state <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? '0 : fifo_head[XLEN-1:0];
  assign inst_pc    = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];
  assign opcode     = inst[6:2];

`ifdef FETCH_PERF_CNT_EN
  logic rsp_discard;

  // Responses thrown away because of a redirect: the one in DRAIN, or one
  // landing in WAIT together with the redirect
  assign rsp_discard = imem.rsp_valid &&
                       ((state == DRAIN) || ((state == WAIT) && flush));

  // Both counters wrap silently
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      perf_flushed <= perf_flushed
                    + (flush ? XLEN'(fifo_count) : 32'd0)
                    + {{(XLEN-1){1'b0}}, rsp_discard};
    end
  end
`else
  // Performance counters not built
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Bench for instr_fetch. A behavioural instruction memory answers each
// accepted request after a programmable latency with a word derived from
// its address. The reference model is the program-order view: consumed
// instructions must appear at consecutive PCs (+4, 32-bit wrap) from the
// reset PC or from the latest redirect target, each carrying mem_word(pc).
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [4:0]  opcode;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int checks   = 0;
  int failures = 0;

  int          mem_lat  = 1;
  int          mem_mode = 0;
  bit          pending  = 1'b0;
  logic [31:0] p_addr   = '0;
  int          wait_left = 0;
  int          n_fires  = 0;
  int          n_reqv   = 0;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .misalign_err   (misalign_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  // Instruction memory: samples the handshake on the rising edge, then
  // updates its outputs shortly after. mem_mode 0: always ready,
  // 1: randomly ready, 2: never ready.
  initial begin : mem_model
    bit          fire;
    bit          delivered;
    logic [31:0] fa;
    bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    forever begin
      @(posedge clk);
      fire      = (bus.req_valid === 1'b1) && (bus.req_ready === 1'b1);
      fa        = bus.addr;
      delivered = (bus.rsp_valid === 1'b1);
      if (bus.req_valid === 1'b1) n_reqv++;
      #1;
      if (delivered) pending = 1'b0;
      if (fire) begin
        pending   = 1'b1;
        p_addr    = fa;
        wait_left = mem_lat - 1;
        n_fires++;
      end else if (pending && wait_left > 0) begin
        wait_left--;
      end
      if (pending && wait_left == 0) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = mem_word(p_addr);
      end else begin
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = $urandom();
      end
      case (mem_mode)
        0:       bus.req_ready = 1'b1;
        1:       bus.req_ready = ($urandom_range(0, 2) != 0);
        default: bus.req_ready = 1'b0;
      endcase
    end
  end

  // Holds reset long enough for any response still in flight to land
  // while the DUT is in reset. Returns on a falling edge with rst high.
  task automatic do_reset();
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_mode       = 0;
    mem_lat        = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    $display("[TB] test_reset");
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_inst_valid got=%0h exp=0", inst_valid); end
    checks++; if (inst !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst got=%h exp=0", inst); end
    checks++; if (inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst_pc got=%h exp=0", inst_pc); end
    checks++; if (opcode !== 5'h0) begin failures++; $display("[TB] FAIL reset_opcode got=%h exp=0", opcode); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_misalign got=%0h exp=0", misalign_err); end
    checks++; if (bus.addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_imem_addr got=%h exp=0", bus.addr); end
    checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid got=%0h exp=0", bus.req_valid); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    logic [31:0] exp_word;
    int first;
    int got;
    do_reset();
    $display("[TB] test_zero_wait");
    rst    = 1'b0;
    exp_pc = 32'h0;
    first  = -1;
    got    = 0;
    for (int c = 1; c <= 40 && got < 4; c++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        if (first < 0) first = c;
        exp_word = mem_word(exp_pc);
        checks++; if (inst_pc !== exp_pc) begin failures++; $display("[TB] FAIL zw_inst_pc got=%h exp=%h", inst_pc, exp_pc); end
        checks++; if (inst !== exp_word) begin failures++; $display("[TB] FAIL zw_inst got=%h exp=%h", inst, exp_word); end
        checks++; if (opcode !== exp_word[6:2]) begin failures++; $display("[TB] FAIL zw_opcode got=%h exp=%h", opcode, exp_word[6:2]); end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
    end
    checks++; if (first != 2) begin failures++; $display("[TB] FAIL zw_first_valid_cycle got=%0d exp=2", first); end
    checks++; if (got != 4) begin failures++; $display("[TB] FAIL zw_count got=%0d exp=4", got); end
  endtask

  task automatic test_stall_full();
    int base;
    do_reset();
    $display("[TB] test_stall_full");
    stall = 1'b1;
    base  = n_fires;
    rst   = 1'b0;
    repeat (8) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_req_valid got=%0h exp=0", bus.req_valid); end
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_inst_valid got=%0h exp=1", inst_valid); end
      checks++; if (inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL full_head_pc got=%h exp=0", inst_pc); end
    end
    checks++; if (n_fires - base != 2) begin failures++; $display("[TB] FAIL full_requests got=%0d exp=2", n_fires - base); end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin failures++; $display("[TB] FAIL full_second_head got=%h exp=4", inst_pc); end
  endtask

  task automatic test_redirect_drain();
    logic [31:0] exp_pc;
    bit redirected;
    int after;
    do_reset();
    $display("[TB] test_redirect_drain");
    mem_lat    = 4;
    rst        = 1'b0;
    exp_pc     = 32'h0;
    redirected = 1'b0;
    after      = 0;
    for (int c = 0; c < 200 && after < 3; c++) begin
      @(negedge clk);
      if (!redirected && pending && p_addr == 32'h8 && bus.rsp_valid !== 1'b1) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        redirected     = 1'b1;
        exp_pc         = 32'h100;
      end else begin
        redirect_valid = 1'b0;
        if (inst_valid === 1'b1) begin
          checks++; if (inst_pc !== exp_pc) begin failures++; $display("[TB] FAIL drain_inst_pc got=%h exp=%h", inst_pc, exp_pc); end
          checks++; if (inst !== mem_word(exp_pc)) begin failures++; $display("[TB] FAIL drain_inst got=%h exp=%h", inst, mem_word(exp_pc)); end
          exp_pc = exp_pc + 32'd4;
          if (redirected) after++;
        end
      end
    end
    redirect_valid = 1'b0;
    checks++; if (!redirected || after != 3) begin failures++; $display("[TB] FAIL drain_progress got=%0d exp=3", after); end
  endtask

  task automatic test_misalign();
    int nr;
    do_reset();
    $display("[TB] test_misalign");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    nr = n_reqv;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      redirect_valid = (c == 4);
      redirect_pc    = 32'h200;
      checks++; if (misalign_err !== 1'b1) begin failures++; $display("[TB] FAIL mis_err got=%0h exp=1", misalign_err); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL mis_inst_valid got=%0h exp=0", inst_valid); end
    end
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (n_reqv != nr) begin failures++; $display("[TB] FAIL mis_requests got=%0d exp=0", n_reqv - nr); end
    do_reset();
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("[TB] FAIL mis_cleared got=%0h exp=0", misalign_err); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    int got;
    do_reset();
    $display("[TB] test_wrap");
    rst = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    got    = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        checks++; if (inst_pc !== exp_pc) begin failures++; $display("[TB] FAIL wrap_inst_pc got=%h exp=%h", inst_pc, exp_pc); end
        checks++; if (inst !== mem_word(exp_pc)) begin failures++; $display("[TB] FAIL wrap_inst got=%h exp=%h", inst, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
    end
    checks++; if (got != 3) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=3", got); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    $display("[TB] test_reset_mid");
    mem_lat = 3;
    rst     = 1'b0;
    @(negedge clk);
    checks++; if (!pending) begin failures++; $display("[TB] FAIL mid_outstanding got=0 exp=1"); end
    rst      = 1'b1;
    mem_mode = 2;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_stale_accepted got=%0h exp=0", inst_valid); end
    end
    mem_mode = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        seen = 1'b1;
        checks++; if (inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL mid_first_pc got=%h exp=0", inst_pc); end
        checks++; if (inst !== mem_word(32'h0)) begin failures++; $display("[TB] FAIL mid_first_inst got=%h exp=%h", inst, mem_word(32'h0)); end
      end
    end
    checks++; if (!seen) begin failures++; $display("[TB] FAIL mid_timeout got=0 exp=1"); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_word;
    int consumed;
    do_reset();
    $display("[TB] test_random");
    mem_mode = 1;
    rst      = 1'b0;
    exp_pc   = 32'h0;
    consumed = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      mem_lat = $urandom_range(1, 3);
      stall   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom() & 32'hFFFF_FFFC;
        exp_pc         = redirect_pc;
      end else begin
        redirect_valid = 1'b0;
        if (inst_valid === 1'b1 && !stall) begin
          exp_word = mem_word(exp_pc);
          checks++; if (inst_pc !== exp_pc) begin failures++; $display("[TB] FAIL rnd_inst_pc got=%h exp=%h", inst_pc, exp_pc); end
          checks++; if (inst !== exp_word) begin failures++; $display("[TB] FAIL rnd_inst got=%h exp=%h", inst, exp_word); end
          checks++; if (opcode !== exp_word[6:2]) begin failures++; $display("[TB] FAIL rnd_opcode got=%h exp=%h", opcode, exp_word[6:2]); end
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
      end
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
    checks++; if (consumed < 100) begin failures++; $display("[TB] FAIL rnd_progress got=%0d exp>=100", consumed); end
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_zero_wait();
    test_stall_full();
    test_redirect_drain();
    test_misalign();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
